percept_serial_arbiter: RTL and testbench

PERCEPT_SERIAL_ARBITER -- requirements
Module: percept_serial_arbiter

---
 rtl/percept_serial_arbiter.sv | 136 +++++++++++++
 tb/tb_percept_serial_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/percept_serial_arbiter.sv
// Purpose: round-robin arbiter for two write requesters, serialising the winner's addr/data onto one idle-high line.
// Latency: accept at T -> addr bits T+1..T+8, separator 1 at T+9, data T+10..T+73, then GAP_CYCLES idle-high cycles.
// Backpressure: reqN_ready is offered only in IDLE to the arbitration winner; the other requester simply waits.
module percept_serial_arbiter #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_addr,
    input  logic [63:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_addr,
    input  logic [63:0] req1_data,
    output logic        req1_ready,
    output logic        ser_out,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        SEP  = 3'd2,
        DATA = 3'd3,
        GAP  = 3'd4
    } state_t;

    // Counter load value for the gap phase; unused when GAP_CYCLES is zero.
    localparam logic [5:0] GAP_LAST = 6'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t      state, state_d;
    logic [5:0]  cnt, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic        last, last_d;      // 1 = requester 1 was granted most recently
    logic        ser_d, busy_d, done_d;
    logic        win0, win1;

    // Round-robin winner: a lone valid wins, a tie goes to the one not granted last.
    always_comb begin
        win0       = req0_valid & (~req1_valid | last);
        win1       = req1_valid & (~req0_valid | ~last);
        req0_ready = (state == IDLE) & ~rst & win0;
        req1_ready = (state == IDLE) & ~rst & win1;
    end

    // Next-state, capture and next-output logic; outputs are computed from the
    // next state so the serial line flops present each bit in its own cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last;
        case (state)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    state_d = ADDR;
                    cnt_d   = 6'd7;
                    addr_d  = req1_ready ? req1_addr : req0_addr;
                    data_d  = req1_ready ? req1_data : req0_data;
                    last_d  = req1_ready;
                end
            end
            ADDR: begin
                if (cnt == 6'd0) begin
                    state_d = SEP;
                end else begin
                    cnt_d = cnt - 6'd1;
                end
            end
            SEP: begin
                state_d = DATA;
                cnt_d   = 6'd63;
            end
            DATA: begin
                if (cnt == 6'd0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LAST;
                    end
                end else begin
                    cnt_d = cnt - 6'd1;
                end
            end
            GAP: begin
                if (cnt == 6'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        ser_d = 1'b1;
        case (state_d)
            ADDR:    ser_d = addr_d[cnt_d[2:0]];
            DATA:    ser_d = data_d[cnt_d];
            default: ser_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DATA) && (cnt_d == 6'd0);
    end

    // State, capture registers and registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            addr_q     <= 8'd0;
            data_q     <= 64'd0;
            last       <= 1'b1;
            ser_out    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            last       <= last_d;
            ser_out    <= ser_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_percept_serial_arbiter.sv
// Purpose: drives two arbiter instances (gap 2 and gap 0) with shared stimulus and checks them against a frame-offset model.
// Latency: expected line outputs derive from the acceptance cycle plus a frame offset.
// Backpressure: grants predicted by the model are queued and popped by a monitor when a DUT handshake is observed.
module tb_percept_serial_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [7:0]  a0 = 8'd0, a1 = 8'd0;
    logic [63:0] d0 = 64'd0, d1 = 64'd0;

    logic r0_g2, r1_g2, so_g2, bz_g2, fd_g2;
    logic r0_g0, r1_g0, so_g0, bz_g0, fd_g0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          gap    [2] = '{2, 0};
    bit          act    [2];
    int          t_acc  [2];
    logic [7:0]  m_addr [2];
    logic [63:0] m_data [2];
    bit          m_last [2];
    int          txq0[$];
    int          txq1[$];

    percept_serial_arbiter #(.GAP_CYCLES(2)) dut_g2 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_g2),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_g2),
        .ser_out(so_g2), .busy(bz_g2), .frame_done(fd_g2)
    );

    percept_serial_arbiter #(.GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_g0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_g0),
        .ser_out(so_g0), .busy(bz_g0), .frame_done(fd_g0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model: a frame accepted at cycle t occupies t+1..t+73+gap;
    // offset k selects addr bit, separator, data bit or gap idle level.
    task automatic model_step(input int i, input logic so, input logic bz, input logic fd,
                              input logic r0, input logic r1);
        logic [4:0] expv, got;
        logic es, eb, ef, w0, w1;
        int k;
        es = 1'b1; eb = 1'b0; ef = 1'b0; w0 = 1'b0; w1 = 1'b0;
        k = cyc - t_acc[i];
        if (act[i] && k >= 1 && k <= 73 + gap[i]) begin
            eb = 1'b1;
            if (k <= 8)
                es = m_addr[i][8 - k];
            else if (k >= 10 && k <= 73)
                es = m_data[i][73 - k];
            ef = (k == 73);
        end else if (!rst) begin
            w0 = v0 && (!v1 || m_last[i]);
            w1 = v1 && (!v0 || !m_last[i]);
        end
        expv = {es, eb, ef, w0, w1};
        got  = {so, bz, fd, r0, r1};
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL line_g%0d cyc=%0d got ser/busy/fd/rdy0/rdy1=%b required %b",
                     gap[i], cyc, got, expv);
        end
        if (rst) begin
            act[i]    = 1'b0;
            m_last[i] = 1'b1;
        end else if (w0 || w1) begin
            act[i]    = 1'b1;
            t_acc[i]  = cyc;
            m_addr[i] = w1 ? a1 : a0;
            m_data[i] = w1 ? d1 : d0;
            m_last[i] = w1;
            if (i == 0) txq0.push_back(w1 ? 1 : 0);
            else        txq1.push_back(w1 ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        model_step(0, so_g2, bz_g2, fd_g2, r0_g2, r1_g2);
        model_step(1, so_g0, bz_g0, fd_g0, r0_g0, r1_g0);
    end

    // Monitor: on every observed handshake, pop the predicted grant and compare.
    always @(negedge clk) begin
        int who, e;
        #1;
        if ((r0_g2 && v0) || (r1_g2 && v1)) begin
            who = (r1_g2 && v1) ? 1 : 0;
            tests++;
            if (txq0.size() == 0) begin
                fails++;
                $display("FAIL grant_g2 cyc=%0d got requester %0d required no grant", cyc, who);
            end else begin
                e = txq0.pop_front();
                if (who != e) begin
                    fails++;
                    $display("FAIL grant_g2 cyc=%0d got requester %0d required %0d", cyc, who, e);
                end
            end
        end
        if ((r0_g0 && v0) || (r1_g0 && v1)) begin
            who = (r1_g0 && v1) ? 1 : 0;
            tests++;
            if (txq1.size() == 0) begin
                fails++;
                $display("FAIL grant_g0 cyc=%0d got requester %0d required no grant", cyc, who);
            end else begin
                e = txq1.pop_front();
                if (who != e) begin
                    fails++;
                    $display("FAIL grant_g0 cyc=%0d got requester %0d required %0d", cyc, who, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; t_acc[i] = 0; m_addr[i] = 8'd0; m_data[i] = 64'd0; m_last[i] = 1'b1;
        end
        step(3);
        rst = 1'b0;

        // Single request 0x55 / 0x100.
        a0 = 8'h55; d0 = 64'h100; v0 = 1'b1;
        step(1);
        v0 = 1'b0;
        step(85);

        // Tie straight after reset: req0 first, req1 held until accepted by both.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        a1 = 8'hAA; d1 = 64'h80; v0 = 1'b1; v1 = 1'b1;
        step(1);
        v0 = 1'b0;
        step(80);
        v1 = 1'b0;
        step(85);

        // Both valid continuously: alternating grants.
        v0 = 1'b1; v1 = 1'b1;
        step(304);
        v0 = 1'b0; v1 = 1'b0;
        step(160);

        // Reset 40 cycles into a req1 frame, then a tie in the first cycle out of reset.
        a1 = 8'h3C; d1 = {$urandom, $urandom}; v1 = 1'b1;
        step(1);
        v1 = 1'b0;
        step(39);
        rst = 1'b1;
        step(1);
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
        step(1);
        v0 = 1'b0; v1 = 1'b0;
        step(85);

        // Back-to-back req0 with inputs changing every cycle, including during DATA.
        v0 = 1'b1;
        for (int c = 0; c < 170; c++) begin
            a0 = 8'($urandom);
            d0 = {$urandom, $urandom};
            step(1);
        end
        v0 = 1'b0;
        step(85);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            v0  = ($urandom_range(0, 3) == 0);
            v1  = ($urandom_range(0, 3) == 0);
            a0  = 8'($urandom);
            a1  = 8'($urandom);
            d0  = {$urandom, $urandom};
            d1  = {$urandom, $urandom};
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        v0 = 1'b0; v1 = 1'b0; rst = 1'b0;
        step(100);

        tests++;
        if (txq0.size() != 0 || txq1.size() != 0) begin
            fails++;
            $display("FAIL grant_drain got %0d/%0d grants never observed required 0/0",
                     txq0.size(), txq1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
